// File: rtl/display_bcd_seq.sv
// display_bcd_seq: iterative double-dabble binary-to-BCD converter that drives
// active-low seven-segment patterns, with leading-zero blanking and overflow dashes.
module display_bcd_seq #(
  parameter int unsigned BIN_W = 10,
  parameter int unsigned N_DIG = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inicio,
  input  logic [BIN_W-1:0]   valor,
  input  logic [3:0]         frac,
  input  logic               supressao,
  output logic               pronto,
  output logic               concluido,
  output logic               overflow,
  output logic [7*N_DIG-1:0] seg_int,
  output logic [6:0]         seg_frac
);

  localparam int unsigned BCD_W = 4 * N_DIG;
  localparam int unsigned SEG_W = 7 * N_DIG;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(N_DIG);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b0000001;
      4'd1:    dec7 = 7'b1001111;
      4'd2:    dec7 = 7'b0010010;
      4'd3:    dec7 = 7'b0000110;
      4'd4:    dec7 = 7'b1001100;
      4'd5:    dec7 = 7'b0100100;
      4'd6:    dec7 = 7'b0100000;
      4'd7:    dec7 = 7'b0001111;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0000100;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_sh;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_frac;
  logic               r_sup;
  logic               r_ovf;

  logic [BCD_W-1:0]   w_bcd_adj;
  logic [SEG_W-1:0]   w_seg_int;

  // Add-3 correction on every nibble that would reach 10 or more after the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < int'(N_DIG); k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // Digit patterns: dashes on overflow, otherwise decode with optional blanking
  // of zeros above the most significant nonzero digit (units always shown).
  always_comb begin
    logic w_lead;
    logic [3:0] w_dig;
    w_seg_int = '1;
    w_lead    = r_sup;
    w_dig     = '0;
    for (int k = int'(N_DIG) - 1; k >= 0; k--) begin
      w_dig = r_bcd[4*k +: 4];
      if (r_ovf) begin
        w_seg_int[7*k +: 7] = SEG_DASH;
      end else if (w_lead && (k != 0) && (w_dig == 4'd0)) begin
        w_seg_int[7*k +: 7] = SEG_BLANK;
      end else begin
        w_seg_int[7*k +: 7] = dec7(w_dig);
        w_lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= OCIOSO;
      pronto    <= 1'b1;
      concluido <= 1'b0;
      overflow  <= 1'b0;
      seg_int   <= {SEG_W{1'b1}};
      seg_frac  <= SEG_BLANK;
      r_sh      <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_frac    <= '0;
      r_sup     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      concluido <= 1'b0;
      case (r_state)
        OCIOSO: begin
          if (inicio) begin
            r_sh    <= valor;
            r_frac  <= frac;
            r_sup   <= supressao;
            r_ovf   <= (64'(valor) >= LIMIT);
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            pronto  <= 1'b0;
            r_state <= CONVERTE;
          end
        end
        CONVERTE: begin
          // Bits carried beyond the top nibble are dropped; overflow was flagged at capture.
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_sh[BIN_W-1]};
          r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ATUALIZA;
        end
        ATUALIZA: begin
          seg_int   <= w_seg_int;
          seg_frac  <= dec7(r_frac);
          overflow  <= r_ovf;
          concluido <= 1'b1;
          pronto    <= 1'b1;
          r_state   <= OCIOSO;
        end
        default: r_state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_display_bcd_seq.sv
// Self-checking bench for display_bcd_seq (BIN_W=10, N_DIG=3): directed table,
// multi-cycle corner sequences and random conversions against a decimal model.
module tb_display_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        inicio;
  logic [9:0]  valor;
  logic [3:0]  frac;
  logic        supressao;
  logic        pronto;
  logic        concluido;
  logic        overflow;
  logic [20:0] seg_int;
  logic [6:0]  seg_frac;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_bcd_seq #(.BIN_W(10), .N_DIG(3)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .valor(valor), .frac(frac),
    .supressao(supressao), .pronto(pronto), .concluido(concluido),
    .overflow(overflow), .seg_int(seg_int), .seg_frac(seg_frac)
  );

  logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  // Reference: decimal digits by division; digit k is leading iff v < 10**k.
  function automatic logic [20:0] model_int(input int v, input bit s);
    logic [20:0] r;
    int p;
    if (v >= 1000) return {3{7'b1111110}};
    p = 1;
    for (int k = 0; k < 3; k++) begin
      if (s && k > 0 && v < p) r[7*k +: 7] = 7'b1111111;
      else r[7*k +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] model_frac(input int f);
    return (f > 9) ? 7'b1111111 : seg_tab[f];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!pronto && n < 40) begin @(negedge clk); n++; end
    chk("ready_before_start", 64'(pronto), 64'd1);
  endtask

  // One full conversion with latency and handshake checks; outputs hold afterwards.
  task automatic run_conv(input int v, input int f, input bit s);
    int n;
    int plow;
    wait_ready();
    valor = 10'(v); frac = 4'(f); supressao = s; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0; valor = 10'($urandom); frac = 4'($urandom); supressao = 1'($urandom);
    n = 1; plow = 0;
    while (!concluido && n < 30) begin
      if (!pronto) plow++;
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'd12);
    chk("pronto_low_cycles", 64'(plow), 64'd11);
    chk("pronto_at_done", 64'(pronto), 64'd1);
    chk("seg_int", 64'(seg_int), 64'(model_int(v, s)));
    chk("seg_frac", 64'(seg_frac), 64'(model_frac(f)));
    chk("overflow", 64'(overflow), 64'(v >= 1000));
    @(negedge clk);
    chk("done_pulse_width", 64'(concluido), 64'd0);
  endtask

  typedef struct {
    int          v;
    int          f;
    bit          s;
    logic [20:0] ei;
    logic [6:0]  ef;
    bit          eo;
  } vec_t;

  vec_t vt [7];
  int   vals [5] = '{5, 999, 1000, 321, 64};

  initial begin
    int n;
    int pulses;
    int first;
    reset = 1'b1; inicio = 1'b0; valor = '0; frac = '0; supressao = 1'b0;
    #1;
    chk("rst_pronto", 64'(pronto), 64'd1);
    chk("rst_concluido", 64'(concluido), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_seg_int", 64'(seg_int), 64'h1FFFFF);
    chk("rst_seg_frac", 64'(seg_frac), 64'h7F);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    vt[0] = '{0,    0,  1'b0, {3{7'b0000001}}, 7'b0000001, 1'b0};
    vt[1] = '{999,  9,  1'b0, {3{7'b0000100}}, 7'b0000100, 1'b0};
    vt[2] = '{1000, 3,  1'b1, {3{7'b1111110}}, 7'b0000110, 1'b1};
    vt[3] = '{42,   0,  1'b1, {7'b1111111, 7'b1001100, 7'b0010010}, 7'b0000001, 1'b0};
    vt[4] = '{0,    0,  1'b1, {7'b1111111, 7'b1111111, 7'b0000001}, 7'b0000001, 1'b0};
    vt[5] = '{705,  12, 1'b0, {7'b0001111, 7'b0000001, 7'b0100100}, 7'b1111111, 1'b0};
    vt[6] = '{1023, 5,  1'b0, {3{7'b1111110}}, 7'b0100100, 1'b1};

    for (int i = 0; i < 7; i++) begin
      run_conv(vt[i].v, vt[i].f, vt[i].s);
      chk("tbl_seg_int", 64'(seg_int), 64'(vt[i].ei));
      chk("tbl_seg_frac", 64'(seg_frac), 64'(vt[i].ef));
      chk("tbl_overflow", 64'(overflow), 64'(vt[i].eo));
    end

    // inicio pulsed mid-conversion must be ignored.
    wait_ready();
    valor = 10'd123; frac = 4'd1; supressao = 1'b0; inicio = 1'b1;
    pulses = 0; first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      inicio = (c == 3);
      valor  = (c == 3) ? 10'd500 : 10'($urandom);
      if (concluido) begin pulses++; if (first == 0) first = c; end
    end
    inicio = 1'b0;
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_latency", 64'(first), 64'd12);
    chk("ign_seg_int", 64'(seg_int), 64'(model_int(123, 0)));

    // Reset in the middle of a conversion, after an overflow result is showing.
    run_conv(1000, 8, 1'b0);
    valor = 10'd888; frac = 4'd2; supressao = 1'b0; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_seg_int", 64'(seg_int), 64'h1FFFFF);
    chk("midrst_seg_frac", 64'(seg_frac), 64'h7F);
    chk("midrst_pronto", 64'(pronto), 64'd1);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (15) begin @(negedge clk); if (concluido) pulses++; end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    run_conv(7, 4, 1'b1);

    // inicio held high: one conversion per 12 cycles.
    wait_ready();
    valor = 10'(vals[0]); frac = 4'd5; supressao = 1'b0; inicio = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!concluido) valor = 10'($urandom);
      end while (!concluido && n < 30);
      chk("b2b_spacing", 64'(n), 64'd12);
      chk("b2b_seg_int", 64'(seg_int), 64'(model_int(vals[i], 0)));
      chk("b2b_overflow", 64'(overflow), 64'(vals[i] >= 1000));
      if (i < 4) valor = 10'(vals[i+1]);
      else inicio = 1'b0;
    end
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      run_conv(int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_bcd_seq.md
Name: display_bcd_seq

Overview:
Sequential, parametrised successor to the stopwatch's combinational seven-segment decoder. It captures a binary value and a tenths digit on a start handshake. It converts the value to N_DIG BCD digits with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock. It then registers active-low segment patterns for all digits at once. Added behaviour: leading-zero suppression, overflow indication (dashes), and ready/done handshake. It sits between the stopwatch counter and the board displays.

Parameters:
BIN_W, 10, width of binary input value; 4 to 32.
N_DIG, 3, number of integer decimal digits driven; 1 to 8; 10**N_DIG must be at most 2**32.

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
inicio  in  1  start request; sampled only when pronto=1
valor  in  BIN_W  binary integer value; captured with inicio
frac  in  4  tenths digit; captured with inicio
supressao  in  1  1 = blank leading zeros; captured with inicio
pronto  out  1  1 = idle, accepting inicio
concluido  out  1  one-cycle pulse, high in the first cycle that new segment outputs are visible
overflow  out  1  1 = last captured valor >= 10**N_DIG
seg_int  out  7*N_DIG  integer digit patterns; digit k (k=0 units) in bits [7k+6:7k]; bit 7k+6 = segment a ... bit 7k = segment g
seg_frac  out  7  tenths digit pattern, same a..g bit order

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While reset=1 and on its release:
  - state OCIOSO, pronto=1, concluido=0, overflow=0;
  - seg_int all ones (blank), seg_frac=7'b1111111;
  - internal shift and BCD registers cleared.
- Segment encoding (a..g, 0 = lit):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111, dash=1111110.
- FSM:
  - OCIOSO: pronto=1. If inicio=1 at edge T:
    - capture valor, frac, supressao;
    - set overflow flag internal = (valor >= 10**N_DIG);
    - clear BCD register (4*N_DIG bits);
    - go to CONVERTE with bit counter = BIN_W.
  - CONVERTE: pronto=0. Each edge performs one double-dabble step:
    - add 3 to every BCD nibble >= 5;
    - then shift {BCD, shift reg} left by 1;
    - decrement the counter.
    - After BIN_W steps (edge T+BIN_W), go to ATUALIZA.
    - BCD bits shifted beyond 4*N_DIG are discarded; overflow is covered by the capture-time compare.
  - ATUALIZA: at edge T+BIN_W+1:
    - register seg_int, seg_frac and overflow;
    - concluido=1 for exactly that cycle;
    - pronto=1 from the same edge;
    - go to OCIOSO.
- Total latency: inicio sampled at T, outputs and concluido visible after edge T+BIN_W+1. The next inicio is accepted at edge T+BIN_W+2 at the earliest.
- inicio while pronto=0 is ignored: no queueing, no effect on the running conversion. Inputs changing during conversion have no effect.
- Outputs hold their last values between conversions.
- Overflow=1: every seg_int digit shows dash and suppression is not applied; seg_frac is still decoded. overflow stays 1 until a later conversion completes with valor in range.
- Suppression=1, no overflow: every digit above the most significant nonzero digit is blank. The units digit is never blanked, so valor=0 shows a single "0".
- frac > 9: seg_frac blank. No other effect.
- Reset asserted mid-conversion: immediate return to the reset state. Partial results are discarded and concluido is not pulsed.

Test Plan:
- Reset, then inicio with valor=0, frac=0, supressao=0 (BIN_W=10, N_DIG=3):
  - pronto low for 11 cycles;
  - concluido pulses once at edge T+11;
  - seg_int = three copies of 0000001, seg_frac=0000001, overflow=0.
- valor=999, frac=9 -> all four digits 0000100, overflow=0. valor=1000 -> overflow=1, all seg_int digits 1111110, seg_frac decoded normally.
- valor=42, supressao=1 -> hundreds blank (1111111), tens 1001100, units 0010010. valor=0, supressao=1 -> hundreds and tens blank, units 0000001.
- frac=12 -> seg_frac=1111111, integer digits unaffected. Pulse inicio with valor=500 three cycles into a running conversion of 123 -> result 123, exactly one concluido pulse.
- Assert reset at cycle 5 of a conversion -> outputs go blank asynchronously, pronto=1, no concluido. A new conversion of 7 then completes normally.
- Back-to-back conversions: inicio held high continuously -> one conversion per 12 cycles, concluido at 12-cycle spacing, each result matches the value captured.
